// File: rtl/dup_test_packer_if.sv
// dup_test_packer_if: handshake bundle around dup_test_packer.
//   in_valid/in_ready/in_data : 13-bit dupTestSt item stream (producer -> packer)
//   flush                     : single-cycle request to close the current partial word
//   out_valid/out_ready       : packed word handshake (packer -> consumer)
//   out_data                  : PACK lanes of 13 bits, lane 0 oldest
//   out_count                 : valid lanes in out_data (1..PACK)
//   out_last                  : word closed by a flush
//   word_count                : saturating count of completed output handshakes
// slave is the packer's view; master is the producer/consumer view.
interface dup_test_packer_if #(
  parameter int unsigned PACK = 2
);
  localparam int unsigned CW = $clog2(PACK + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [12:0]          in_data;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [PACK*13-1:0]   out_data;
  logic [CW-1:0]        out_count;
  logic                 out_last;
  logic [15:0]          word_count;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last, word_count
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last, word_count
  );
endinterface

// File: rtl/dup_test_packer.sv
// dup_test_packer: packs 13-bit dupTestSt items into words of PACK lanes.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : dup_test_packer_if.slave (input stream, flush, output word, word_count)
// PACK defaults to 2 (the DSIZE2 lane count); legal range 1..8.
// An accumulator holds up to PACK-1 items; a one-word output register lets
// the accumulator keep filling while the consumer stalls. A flush that cannot
// reach the output register is parked as a pending flush, which blocks input
// until the partial word has been handed over.
module dup_test_packer #(
  parameter int unsigned PACK = 2
) (
  input logic             clk,
  input logic             rst,
  dup_test_packer_if.slave bus
);
  localparam int unsigned DW = 13;
  localparam int unsigned CW = $clog2(PACK + 1);
  localparam logic [CW-1:0] LAST_LANE = CW'(PACK - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(PACK);

  typedef enum logic {ST_FILL, ST_FLUSH_PEND} state_e;
  state_e state, stateNext;

  logic [DW-1:0]      acc [PACK];
  logic [CW-1:0]      accCnt, accCntNext;
  logic               outValid;
  logic [PACK*DW-1:0] outData;
  logic [CW-1:0]      outCount;
  logic               outLast;
  logic [15:0]        wordCount;

  logic               outFree, inReady, accept, fullAccept, handshake;
  logic [CW-1:0]      nItems;
  logic [PACK*DW-1:0] word;
  logic               load, loadLast, storeLane;
  logic [CW-1:0]      loadCount;

  assign outFree    = !outValid || bus.out_ready;
  assign inReady    = !rst && (state == ST_FILL) && ((accCnt != LAST_LANE) || outFree);
  assign accept     = bus.in_valid && inReady;
  assign fullAccept = accept && (accCnt == LAST_LANE);
  assign nItems     = accCnt + CW'(accept);
  assign handshake  = outValid && bus.out_ready;

  // Candidate word: stored lanes, then the item accepted this cycle, zeros above.
  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < PACK; k++) begin
      if (CW'(k) < accCnt)
        word[k*DW +: DW] = acc[k];
      else if (CW'(k) == accCnt && accept)
        word[k*DW +: DW] = bus.in_data;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FILL;
    else     state <= stateNext;
  end

  // Next-state: park a flush that holds items but cannot reach the output register.
  always_comb begin
    stateNext = state;
    unique case (state)
      ST_FILL:
        if (bus.flush && !fullAccept && (nItems != '0) && !outFree)
          stateNext = ST_FLUSH_PEND;
      ST_FLUSH_PEND:
        if (outFree) stateNext = ST_FILL;
    endcase
  end

  // Output decode: what loads into the output register and how acc advances.
  always_comb begin
    load       = 1'b0;
    loadCount  = '0;
    loadLast   = 1'b0;
    storeLane  = 1'b0;
    accCntNext = accCnt;
    if (fullAccept) begin
      load       = 1'b1;
      loadCount  = FULL_CNT;
      loadLast   = bus.flush;
      accCntNext = '0;
    end else if (state == ST_FLUSH_PEND) begin
      // Input is blocked here, so word holds exactly the parked items.
      if (outFree) begin
        load       = 1'b1;
        loadCount  = accCnt;
        loadLast   = 1'b1;
        accCntNext = '0;
      end
    end else if (bus.flush && (nItems != '0)) begin
      if (outFree) begin
        load       = 1'b1;
        loadCount  = nItems;
        loadLast   = 1'b1;
        accCntNext = '0;
      end else if (accept) begin
        storeLane  = 1'b1;
        accCntNext = accCnt + CW'(1);
      end
    end else if (accept) begin
      storeLane  = 1'b1;
      accCntNext = accCnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < PACK; k++) begin
      if (storeLane && CW'(k) == accCnt) acc[k] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accCnt    <= '0;
      outValid  <= 1'b0;
      outData   <= '0;
      outCount  <= '0;
      outLast   <= 1'b0;
      wordCount <= '0;
    end else begin
      accCnt <= accCntNext;
      if (load) begin
        outValid <= 1'b1;
        outData  <= word;
        outCount <= loadCount;
        outLast  <= loadLast;
      end else if (handshake) begin
        outValid <= 1'b0;
      end
      if (handshake && wordCount != '1) wordCount <= wordCount + 16'd1;
    end
  end

  assign bus.in_ready   = inReady;
  assign bus.out_valid  = outValid;
  assign bus.out_data   = outData;
  assign bus.out_count  = outCount;
  assign bus.out_last   = outLast;
  assign bus.word_count = wordCount;
endmodule

// File: tb/tb_dup_test_packer.sv
module tb_dup_test_packer;
  localparam int unsigned PACK = 2;
  localparam int unsigned CW   = $clog2(PACK + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dup_test_packer_if #(.PACK(PACK)) bus ();
  dup_test_packer #(.PACK(PACK)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [PACK*13-1:0] data;
    logic [CW-1:0]      count;
    logic               last;
  } word_t;

  logic [12:0] accQ [$];
  word_t       waitQ [$];
  bit          mInit  = 0;
  bit          mValid = 0;
  word_t       mWord  = '{data: '0, count: '0, last: 1'b0};
  logic [15:0] mWc    = '0;

  function automatic word_t closeWord(input logic lastFlag);
    word_t w;
    w.data  = '0;
    w.count = CW'(accQ.size());
    w.last  = lastFlag;
    for (int i = 0; i < accQ.size(); i++) w.data[i*13 +: 13] = accQ[i];
    return w;
  endfunction

  always @(posedge clk) begin
    bit    outFree, expReady, hs, closed, loaded;
    word_t w;
    mInit = 1;
    if (rst) begin
      accQ.delete();
      waitQ.delete();
      mValid = 0;
      mWord  = '{data: '0, count: '0, last: 1'b0};
      mWc    = '0;
    end else begin
      outFree  = !mValid || bus.out_ready;
      expReady = (waitQ.size() == 0) && ((accQ.size() != PACK - 1) || outFree);
      hs       = mValid && bus.out_ready;
      if (hs && mWc != 16'hFFFF) mWc++;
      closed = 0;
      loaded = 0;
      if (bus.in_valid && expReady) accQ.push_back(bus.in_data);
      if (accQ.size() == PACK) begin
        w = closeWord(bus.flush); accQ.delete(); closed = 1;
      end else if (bus.flush && waitQ.size() == 0 && accQ.size() > 0) begin
        w = closeWord(1'b1); accQ.delete(); closed = 1;
      end
      if (closed) begin
        if (outFree) begin mWord = w; loaded = 1; end
        else waitQ.push_back(w);
      end else if (waitQ.size() != 0 && outFree) begin
        mWord = waitQ.pop_front(); loaded = 1;
      end
      if (loaded) mValid = 1;
      else if (hs) mValid = 0;
    end
  end

  // Single compare process against the model.
  always @(negedge clk) begin
    bit expReady;
    if (mInit) begin
      expReady = !rst && (waitQ.size() == 0) &&
                 ((accQ.size() != PACK - 1) || !mValid || bus.out_ready);
      check("m_in_ready",   64'(bus.in_ready),   64'(expReady));
      check("m_out_valid",  64'(bus.out_valid),  64'(mValid));
      check("m_word_count", 64'(bus.word_count), 64'(mWc));
      if (mValid) begin
        check("m_out_data",  64'(bus.out_data),  64'(mWord.data));
        check("m_out_count", 64'(bus.out_count), 64'(mWord.count));
        check("m_out_last",  64'(bus.out_last),  64'(mWord.last));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sendItem(input logic [12:0] d, input logic fl);
    int unsigned w = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.flush    = fl;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin w++; @(negedge clk); end
    check("accept_timeout", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic pulseFlush();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",   64'(bus.in_ready),   64'd0);
    check("rst_out_valid",  64'(bus.out_valid),  64'd0);
    check("rst_out_data",   64'(bus.out_data),   64'd0);
    check("rst_out_count",  64'(bus.out_count),  64'd0);
    check("rst_out_last",   64'(bus.out_last),   64'd0);
    check("rst_word_count", 64'(bus.word_count), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Full word
    step();
    sendItem(13'h0001, 1'b0);
    sendItem(13'h1FFF, 1'b0);
    @(negedge clk);
    check("full_data",  64'(bus.out_data),  64'h3FFE001);
    check("full_count", 64'(bus.out_count), 64'd2);
    check("full_last",  64'(bus.out_last),  64'd0);
    @(negedge clk);
    check("full_wc", 64'(bus.word_count), 64'd1);

    // Partial flush
    step();
    sendItem(13'h0ABC, 1'b0);
    pulseFlush();
    @(negedge clk);
    check("part_data",  64'(bus.out_data),  64'h0000ABC);
    check("part_count", 64'(bus.out_count), 64'd1);
    check("part_last",  64'(bus.out_last),  64'd1);

    // Flush coincident with completing accept
    step();
    sendItem(13'h0002, 1'b0);
    sendItem(13'h0003, 1'b1);
    @(negedge clk);
    check("coin_data",  64'(bus.out_data),  64'h0006002);
    check("coin_count", 64'(bus.out_count), 64'd2);
    check("coin_last",  64'(bus.out_last),  64'd1);
    @(negedge clk);
    check("coin_no_extra", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("coin_no_extra2", 64'(bus.out_valid), 64'd0);

    // Backpressure
    step();
    bus.out_ready = 1'b0;
    sendItem(13'h0101, 1'b0);
    sendItem(13'h0102, 1'b0);
    sendItem(13'h0103, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 13'h0104;
    @(negedge clk);
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    check("bp_word1",        64'(bus.out_data), 64'h0204101);
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_rel", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_word2_valid", 64'(bus.out_valid),  64'd1);
    check("bp_word2",       64'(bus.out_data),   64'h0208103);
    check("bp_wc",          64'(bus.word_count), 64'd4);
    step();
    step();

    // Pending flush
    bus.out_ready = 1'b0;
    sendItem(13'h0201, 1'b0);
    sendItem(13'h0202, 1'b0);
    sendItem(13'h0203, 1'b0);
    pulseFlush();
    @(negedge clk);
    check("pend_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    pulseFlush();
    @(negedge clk);
    check("pend_hold_data", 64'(bus.out_data), 64'h0404201);
    check("pend_in_ready2", 64'(bus.in_ready), 64'd0);
    step();
    bus.out_ready = 1'b1;
    step();
    @(negedge clk);
    check("pend_data",     64'(bus.out_data),  64'h0000203);
    check("pend_count",    64'(bus.out_count), 64'd1);
    check("pend_last",     64'(bus.out_last),  64'd1);
    check("pend_in_ready", 64'(bus.in_ready),  64'd1);
    step();

    // Streaming throughput
    for (int i = 0; i < 6; i++) sendItem(13'(16'h0300 + i), 1'b0);
    step();
    step();

    // Reset mid-stream
    sendItem(13'h0055, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_wc",    64'(bus.word_count), 64'd0);
    check("mid_rst_valid", 64'(bus.out_valid),  64'd0);
    step();
    sendItem(13'h0010, 1'b0);
    sendItem(13'h0020, 1'b0);
    @(negedge clk);
    check("mid_rst_data",  64'(bus.out_data),  64'h0040010);
    check("mid_rst_count", 64'(bus.out_count), 64'd2);
    step();
    pulseFlush();
    @(negedge clk);
    check("empty_flush_valid", 64'(bus.out_valid),  64'd0);
    check("empty_flush_wc",    64'(bus.word_count), 64'd1);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
